cordic_fix2float: RTL and testbench
===================================

Name: cordic_fix2float

Overview:
- Output-side converter for the CORDIC cosine accelerator; the inverse of the float-to-fixed decode at the accelerator input.
- Takes the unsigned fixed-point CORDIC result plus a sign bit and produces an IEEE-754 single-precision word.
- Multi-cycle: a 5-step leading-zero normalizer, then a rounding stage, under a start/done handshake.
- Sits between the CORDIC core `result` and the custom-instruction result bus.

Parameters:
- FRAC_BITS, 31, number of fractional bits in dataa (31 = Q1.31: bit31 weight 1.0); legal 0..31.
- ROUND_MODE, 1, 0 = truncate, 1 = round-to-nearest-even.

Ports:
- clock  in  1  rising-edge clock.
- aclr  in  1  asynchronous active-high reset.
- clk_en  in  1  global enable; when low all state, including done, holds.
- start  in  1  request; sampled only in IDLE with clk_en=1.
- dataa  in  32  unsigned fixed-point magnitude.
- sign_in  in  1  sign of the value, copied to result[31].
- result  out  32  IEEE-754 single; registered.
- done  out  1  one-cycle pulse (counted in enabled cycles) when result updates.
- busy  out  1  high from the capture edge until the done edge.

Behaviour:
- Reset (aclr=1, asynchronous, any state): state=IDLE, result=0, done=0, busy=0, internal regs=0.
- States and transitions:
  - IDLE: with start=1 and clk_en=1, capture dataa into work reg W, sign_in into S, lzc=0; go to NORM with step=0; busy=1.
  - NORM (step 0..4, shift amount 16,8,4,2,1): if the top `amt` bits of W are zero, W <= W << amt and lzc += amt; otherwise no change. After step 4, go to ROUND.
  - ROUND:
    - If W==0: result <= {S,31'b0} (signed zero).
    - Else: E = 158 - FRAC_BITS - lzc (8 bits); M = W[30:8]; G = W[7]; St = |W[6:0].
    - If ROUND_MODE=1 and G & (St | M[0]): M = M + 1. On carry-out, M = 0 and E = E + 1.
    - result <= {S,E,M}; done <= 1; busy <= 0; go to IDLE.
- done clears on the next enabled edge.
- Latency: 6 enabled edges from the capture edge to result/done valid (5 NORM + 1 ROUND).
- Exponent cannot underflow or overflow for legal FRAC_BITS (range 96..159). Denormals, inf and NaN are never produced.
- start during NORM or ROUND is ignored (no queuing). start in the same cycle done is high is accepted normally.
- clk_en=0 freezes state, step, W, lzc, result, done and busy. Exactly 6 enabled edges are still required.
- result holds its last value until the next ROUND; only aclr clears it.
- aclr asserted mid-NORM: the conversion is abandoned and no done pulse is produced.

Test Plan:
1. dataa=0x80000000, sign_in=0, FRAC_BITS=31 -> result=0x3F800000, done high exactly 6 edges after start, busy low afterwards.
2. dataa=0x4DBA76D4 (CORDIC gain K) -> lzc=1, G=1, St=1, so it rounds up to result=0x3F1B74EE. With ROUND_MODE=0 -> 0x3F1B74ED.
3. dataa=0 with sign_in=1 -> result=0x80000000. dataa=0x00000001, sign_in=1 -> 0xB0000000.
4. Rounding corners:
   - dataa=0xFFFFFFFF, RNE -> 0x40000000 (mantissa carry, exponent +1).
   - dataa=0xFFFFFFFF, truncate -> 0x3FFFFFFF.
   - Ties: 0x01000001 -> 0x3C000000 (tie, even, no round); 0x01000003 -> 0x3C000002 (tie, odd, round up).
5. Handshake:
   - start re-asserted during NORM -> ignored, only one done.
   - clk_en low for 3 cycles mid-NORM -> done arrives 9 clocks after start, same result.
   - back-to-back start on the done cycle -> second conversion completes 6 edges later.
6. aclr pulsed asynchronously (between edges) at NORM step 2 -> result=0, busy=0, done=0 immediately and no later done. A fresh start then converts correctly.

Source files
------------

// File: rtl/cordic_fix2float_if.sv
// Handshake and data bundle between the custom-instruction front end and the
// fixed-to-float converter at the CORDIC output.
interface cordic_fix2float_if;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic        sign_in;
  logic [31:0] result;
  logic        done;
  logic        busy;

  modport master (
    output clk_en, start, dataa, sign_in,
    input  result, done, busy
  );

  modport slave (
    input  clk_en, start, dataa, sign_in,
    output result, done, busy
  );
endinterface

// File: rtl/cordic_fix2float.sv
// Converts the unsigned fixed-point CORDIC magnitude plus a sign into an
// IEEE-754 single, using a 5-step leading-zero normalizer and a rounding step.
module cordic_fix2float #(
  parameter int FRAC_BITS  = 31,
  parameter int ROUND_MODE = 1
) (
  input  logic               clock,
  input  logic               aclr,
  cordic_fix2float_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2
  } state_t;

  // Exponent of a value whose leading one already sits at bit 31 of W.
  localparam logic [7:0] E_BASE = 8'(158 - FRAC_BITS);

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [31:0] w_q, w_d;
  logic        s_q, s_d;
  logic [4:0]  lzc_q, lzc_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic [4:0]  amt;
  logic        top_zero;
  logic [31:0] w_shifted;

  logic [22:0] mant;
  logic [23:0] mant_inc;
  logic [7:0]  expo;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [31:0] round_word;

  always_comb begin
    amt       = 5'd0;
    top_zero  = 1'b0;
    w_shifted = w_q;
    case (step_q)
      3'd0: begin
        amt       = 5'd16;
        top_zero  = (w_q[31:16] == 16'h0000);
        w_shifted = {w_q[15:0], 16'h0000};
      end
      3'd1: begin
        amt       = 5'd8;
        top_zero  = (w_q[31:24] == 8'h00);
        w_shifted = {w_q[23:0], 8'h00};
      end
      3'd2: begin
        amt       = 5'd4;
        top_zero  = (w_q[31:28] == 4'h0);
        w_shifted = {w_q[27:0], 4'h0};
      end
      3'd3: begin
        amt       = 5'd2;
        top_zero  = (w_q[31:30] == 2'b00);
        w_shifted = {w_q[29:0], 2'b00};
      end
      3'd4: begin
        amt       = 5'd1;
        top_zero  = ~w_q[31];
        w_shifted = {w_q[30:0], 1'b0};
      end
      default: begin
        amt       = 5'd0;
        top_zero  = 1'b0;
        w_shifted = w_q;
      end
    endcase
  end

  // The leading one of a normalized W is implicit; the 23 bits under it form
  // the mantissa and the remaining byte supplies guard and sticky.
  always_comb begin
    mant     = w_q[30:8];
    guard    = w_q[7];
    sticky   = |w_q[6:0];
    expo     = E_BASE - {3'b000, lzc_q};
    mant_inc = {1'b0, w_q[30:8]} + 24'd1;
    round_up = (ROUND_MODE != 0) && guard && (sticky || w_q[8]);
    if (round_up) begin
      if (mant_inc[23]) begin
        mant = 23'd0;
        expo = expo + 8'd1;
      end else begin
        mant = mant_inc[22:0];
      end
    end
    if (w_q == 32'd0) begin
      round_word = {s_q, 31'd0};
    end else begin
      round_word = {s_q, expo, mant};
    end
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    w_d      = w_q;
    s_d      = s_q;
    lzc_d    = lzc_q;
    result_d = result_q;
    done_d   = done_q;
    busy_d   = busy_q;
    if (bus.clk_en) begin
      done_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            w_d     = bus.dataa;
            s_d     = bus.sign_in;
            lzc_d   = 5'd0;
            step_d  = 3'd0;
            busy_d  = 1'b1;
            state_d = NORM;
          end
        end
        NORM: begin
          if (top_zero) begin
            w_d   = w_shifted;
            lzc_d = lzc_q + amt;
          end
          if (step_q == 3'd4) begin
            state_d = ROUND;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
        ROUND: begin
          result_d = round_word;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state_q  <= IDLE;
      step_q   <= 3'd0;
      w_q      <= 32'd0;
      s_q      <= 1'b0;
      lzc_q    <= 5'd0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      w_q      <= w_d;
      s_q      <= s_d;
      lzc_q    <= lzc_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_cordic_fix2float.sv
// Bench for cordic_fix2float: a round-to-nearest-even and a truncating instance
// share one stimulus stream and are compared against an arithmetic float model.
module tb_cordic_fix2float;

  localparam int FRAC = 31;

  logic clock = 1'b0;
  logic aclr  = 1'b1;

  int errors = 0;
  int checks = 0;

  cordic_fix2float_if bus_rne();
  cordic_fix2float_if bus_trn();

  assign bus_trn.clk_en  = bus_rne.clk_en;
  assign bus_trn.start   = bus_rne.start;
  assign bus_trn.dataa   = bus_rne.dataa;
  assign bus_trn.sign_in = bus_rne.sign_in;

  cordic_fix2float #(.FRAC_BITS(FRAC), .ROUND_MODE(1)) dut_rne (
    .clock (clock),
    .aclr  (aclr),
    .bus   (bus_rne.slave)
  );

  cordic_fix2float #(.FRAC_BITS(FRAC), .ROUND_MODE(0)) dut_trn (
    .clock (clock),
    .aclr  (aclr),
    .bus   (bus_trn.slave)
  );

  always #5 clock = ~clock;

  // Value is d / 2^FRAC; place the leading one, keep 24 significant bits and
  // round the discarded tail as a plain number against half an ulp.
  function automatic logic [31:0] ref_float(input logic [31:0] d, input logic s, input bit rne);
    int p;
    int e;
    longint unsigned mant;
    longint unsigned rem;
    longint unsigned half;
    logic [7:0]  e8;
    logic [22:0] m23;
    if (d == 32'd0) return {s, 31'd0};
    p = 31;
    while (d[p] == 1'b0) p--;
    e = p - FRAC + 127;
    if (p > 23) begin
      mant = 64'(d) >> (p - 23);
      rem  = 64'(d) & ((64'd1 << (p - 23)) - 64'd1);
      half = 64'd1 << (p - 24);
      if (rne && ((rem > half) || (rem == half && mant[0]))) mant = mant + 64'd1;
    end else begin
      mant = 64'(d) << (23 - p);
    end
    if (mant == (64'd1 << 24)) begin
      mant = mant >> 1;
      e    = e + 1;
    end
    e8  = e[7:0];
    m23 = mant[22:0];
    return {s, e8, m23};
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic run_conv(input logic [31:0] d, input logic s, output int edges,
                          output logic [31:0] r_rne, output logic [31:0] r_trn,
                          output logic busy_after);
    bus_rne.dataa   = d;
    bus_rne.sign_in = s;
    bus_rne.start   = 1'b1;
    tick();
    bus_rne.start = 1'b0;
    edges = 0;
    while (bus_rne.done !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
    r_rne      = bus_rne.result;
    r_trn      = bus_trn.result;
    busy_after = bus_rne.busy;
  endtask

  task automatic test_reset;
    bus_rne.clk_en  = 1'b1;
    bus_rne.start   = 1'b0;
    bus_rne.dataa   = 32'd0;
    bus_rne.sign_in = 1'b0;
    aclr = 1'b1;
    #12;
    checks++;
    if (bus_rne.result !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_result got=%h want=%h", bus_rne.result, 32'd0);
    end
    checks++;
    if (bus_rne.done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_done got=%b want=0", bus_rne.done);
    end
    checks++;
    if (bus_rne.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_busy got=%b want=0", bus_rne.busy);
    end
    tick();
    aclr = 1'b0;
    tick();
  endtask

  task automatic test_directed;
    logic [31:0] vec_d   [8] = '{32'h80000000, 32'h4DBA76D4, 32'h00000000, 32'h00000001,
                                 32'hFFFFFFFF, 32'h01000001, 32'h01000003, 32'h80000000};
    logic        vec_s   [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] vec_rne [8] = '{32'h3F800000, 32'h3F1B74EE, 32'h80000000, 32'hB0000000,
                                 32'h40000000, 32'h3C000000, 32'h3C000002, 32'hBF800000};
    logic [31:0] vec_trn [8] = '{32'h3F800000, 32'h3F1B74ED, 32'h80000000, 32'hB0000000,
                                 32'h3FFFFFFF, 32'h3C000000, 32'h3C000001, 32'hBF800000};
    int edges;
    logic [31:0] r_rne, r_trn;
    logic busy_after;
    for (int i = 0; i < 8; i++) begin
      run_conv(vec_d[i], vec_s[i], edges, r_rne, r_trn, busy_after);
      checks++;
      if (edges !== 6) begin
        errors++;
        $display("[TB] FAIL directed_latency[%0d] got=%0d want=6", i, edges);
      end
      checks++;
      if (r_rne !== vec_rne[i]) begin
        errors++;
        $display("[TB] FAIL directed_rne[%0d] d=%h got=%h want=%h", i, vec_d[i], r_rne, vec_rne[i]);
      end
      checks++;
      if (r_trn !== vec_trn[i]) begin
        errors++;
        $display("[TB] FAIL directed_trunc[%0d] d=%h got=%h want=%h", i, vec_d[i], r_trn, vec_trn[i]);
      end
      checks++;
      if (busy_after !== 1'b0) begin
        errors++;
        $display("[TB] FAIL directed_busy[%0d] got=%b want=0", i, busy_after);
      end
      tick();
      checks++;
      if (bus_rne.done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL directed_done_width[%0d] got=%b want=0", i, bus_rne.done);
      end
    end
  endtask

  task automatic test_random;
    int edges;
    logic [31:0] d, r_rne, r_trn, want_rne, want_trn;
    logic s, busy_after;
    for (int i = 0; i < 60; i++) begin
      d = $urandom >> $urandom_range(0, 31);
      if (i % 5 == 0) d = (d & 32'hFFFFFF00) | 32'h00000080;
      s = 1'($urandom_range(0, 1));
      want_rne = ref_float(d, s, 1'b1);
      want_trn = ref_float(d, s, 1'b0);
      run_conv(d, s, edges, r_rne, r_trn, busy_after);
      checks++;
      if (r_rne !== want_rne || edges !== 6) begin
        errors++;
        $display("[TB] FAIL random_rne d=%h s=%b got=%h edges=%0d want=%h edges=6", d, s, r_rne, edges, want_rne);
      end
      checks++;
      if (r_trn !== want_trn) begin
        errors++;
        $display("[TB] FAIL random_trunc d=%h s=%b got=%h want=%h", d, s, r_trn, want_trn);
      end
      if (i % 3 == 0) tick();
    end
  endtask

  task automatic test_start_ignored;
    int dones = 0;
    logic [31:0] seen = 32'd0;
    logic [31:0] want = ref_float(32'h4DBA76D4, 1'b0, 1'b1);
    bus_rne.dataa   = 32'h4DBA76D4;
    bus_rne.sign_in = 1'b0;
    bus_rne.start   = 1'b1;
    tick();
    checks++;
    if (bus_rne.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_after_capture got=%b want=1", bus_rne.busy);
    end
    bus_rne.dataa   = 32'h00000001;
    bus_rne.sign_in = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i == 3) bus_rne.start = 1'b0;
      tick();
      if (bus_rne.done === 1'b1) begin
        dones++;
        seen = bus_rne.result;
      end
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("[TB] FAIL ignored_start_dones got=%0d want=1", dones);
    end
    checks++;
    if (seen !== want) begin
      errors++;
      $display("[TB] FAIL ignored_start_result got=%h want=%h", seen, want);
    end
  endtask

  task automatic test_clk_en_stall;
    int edges = 0;
    logic [31:0] want = ref_float(32'h0003A5C1, 1'b1, 1'b1);
    bus_rne.dataa   = 32'h0003A5C1;
    bus_rne.sign_in = 1'b1;
    bus_rne.start   = 1'b1;
    tick();
    bus_rne.start = 1'b0;
    tick();
    tick();
    edges = 2;
    bus_rne.clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      edges++;
      checks++;
      if (bus_rne.busy !== 1'b1 || bus_rne.done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_hold[%0d] busy=%b done=%b want busy=1 done=0", i, bus_rne.busy, bus_rne.done);
      end
    end
    bus_rne.clk_en = 1'b1;
    while (bus_rne.done !== 1'b1 && edges < 30) begin
      tick();
      edges++;
    end
    checks++;
    if (edges !== 9) begin
      errors++;
      $display("[TB] FAIL stall_latency got=%0d want=9", edges);
    end
    checks++;
    if (bus_rne.result !== want) begin
      errors++;
      $display("[TB] FAIL stall_result got=%h want=%h", bus_rne.result, want);
    end
    // done must survive a frozen cycle
    bus_rne.clk_en = 1'b0;
    tick();
    checks++;
    if (bus_rne.done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_done_hold got=%b want=1", bus_rne.done);
    end
    bus_rne.clk_en = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back;
    int edges;
    logic [31:0] r_rne, r_trn;
    logic busy_after;
    logic [31:0] d2 = 32'h00F0F0F1;
    run_conv(32'h12345678, 1'b0, edges, r_rne, r_trn, busy_after);
    checks++;
    if (r_rne !== ref_float(32'h12345678, 1'b0, 1'b1)) begin
      errors++;
      $display("[TB] FAIL b2b_first got=%h want=%h", r_rne, ref_float(32'h12345678, 1'b0, 1'b1));
    end
    run_conv(d2, 1'b1, edges, r_rne, r_trn, busy_after);
    checks++;
    if (edges !== 6) begin
      errors++;
      $display("[TB] FAIL b2b_latency got=%0d want=6", edges);
    end
    checks++;
    if (r_rne !== ref_float(d2, 1'b1, 1'b1) || r_trn !== ref_float(d2, 1'b1, 1'b0)) begin
      errors++;
      $display("[TB] FAIL b2b_second got=%h/%h want=%h/%h", r_rne, r_trn,
               ref_float(d2, 1'b1, 1'b1), ref_float(d2, 1'b1, 1'b0));
    end
    tick();
  endtask

  task automatic test_async_reset;
    int dones = 0;
    int edges;
    logic [31:0] r_rne, r_trn;
    logic busy_after;
    bus_rne.dataa   = 32'h00ABCDEF;
    bus_rne.sign_in = 1'b0;
    bus_rne.start   = 1'b1;
    tick();
    bus_rne.start = 1'b0;
    tick();
    tick();
    #2 aclr = 1'b1;
    #1;
    checks++;
    if (bus_rne.result !== 32'd0 || bus_rne.busy !== 1'b0 || bus_rne.done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset result=%h busy=%b done=%b want 0/0/0",
               bus_rne.result, bus_rne.busy, bus_rne.done);
    end
    #2 aclr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus_rne.done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("[TB] FAIL async_reset_no_done got=%0d want=0", dones);
    end
    run_conv(32'h00ABCDEF, 1'b0, edges, r_rne, r_trn, busy_after);
    checks++;
    if (r_rne !== ref_float(32'h00ABCDEF, 1'b0, 1'b1) || edges !== 6) begin
      errors++;
      $display("[TB] FAIL async_reset_recover got=%h edges=%0d want=%h edges=6",
               r_rne, edges, ref_float(32'h00ABCDEF, 1'b0, 1'b1));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_clk_en_stall();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
